// File: rtl/serial_eq_comparator.sv
// serial_eq_comparator
// Compares two words that arrive serially as 2-bit beats, MSB first.
// The block accumulates per-beat equality and counts the accepted beats.
// A word ends on the beat marked Last_SI or on the NUM_DIBITS-th beat,
// whichever comes first. The block then holds a result (equality, length
// error, beat count) until the downstream side takes it.

// comparator_2
// Equality of two dibits, built bit by bit and reduced.
module comparator_2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       eq
);

  logic [1:0] bit_eq;

  // One XNOR per bit position; the dibits are equal when every bit matches.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bit
      assign bit_eq[gi] = ~(a[gi] ^ b[gi]);
    end
  endgenerate

  assign eq = &bit_eq;

endmodule

module serial_eq_comparator #(
  parameter int NUM_DIBITS = 4
) (
  input  logic                        Clk_CI,
  input  logic                        Rst_RI,
  input  logic                        InValid_SI,
  output logic                        InReady_SO,
  input  logic [1:0]                  A_DI,
  input  logic [1:0]                  B_DI,
  input  logic                        Last_SI,
  output logic                        OutValid_SO,
  input  logic                        OutReady_SI,
  output logic                        Equal_DO,
  output logic                        LenErr_DO,
  output logic [$clog2(NUM_DIBITS):0] Count_DO
);

  // One extra bit over $clog2 so that the value NUM_DIBITS itself fits
  // (e.g. 4 beats needs 3 bits, 64 beats needs 7 bits).
  localparam int CW = $clog2(NUM_DIBITS) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(NUM_DIBITS);
  localparam logic [CW-1:0] ONE_COUNT  = CW'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    RESULT = 2'd2
  } state_t;

  state_t state_reg;
  state_t state_next;

  // Running word state.
  logic          eq_acc_reg;
  logic          eq_acc_next;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;

  // Result registers; they keep the last result outside RESULT.
  logic          equal_reg;
  logic          equal_next;
  logic          len_err_reg;
  logic          len_err_next;
  logic [CW-1:0] count_out_reg;
  logic [CW-1:0] count_out_next;

  // Per-beat and per-cycle helpers.
  logic          beat_eq;
  logic          accept;
  logic          result_taken;
  logic          word_start;
  logic [CW-1:0] count_inc;
  logic          eq_inc;
  logic          at_full;
  logic          terminate;
  logic          len_err_now;

  comparator_2 u_cmp (
    .a  (A_DI),
    .b  (B_DI),
    .eq (beat_eq)
  );

  // A beat is taken only while ready; the result leaves on its handshake.
  assign accept       = InValid_SI && InReady_SO;
  assign result_taken = OutValid_SO && OutReady_SI;

  // A beat accepted in IDLE opens a fresh word: count restarts at one and
  // the accumulator is loaded rather than ANDed.
  assign word_start = (state_reg == IDLE);
  assign count_inc  = word_start ? ONE_COUNT : (count_reg + ONE_COUNT);
  assign eq_inc     = word_start ? beat_eq : (eq_acc_reg && beat_eq);
  assign at_full    = (count_inc == FULL_COUNT);

  // The word closes on Last_SI or on the last permitted beat. The length
  // is correct only when both coincide; any other closing is an error.
  assign terminate   = accept && (Last_SI || at_full);
  assign len_err_now = !(Last_SI && at_full);

  // State register; reset wins over any beat or result handshake.
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: IDLE/ACCUM collect beats, RESULT waits for the taker.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = terminate ? RESULT : ACCUM;
        end
      end
      ACCUM: begin
        if (terminate) begin
          state_next = RESULT;
        end
      end
      RESULT: begin
        if (result_taken) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // FSM outputs: ready while collecting (never in reset), valid in RESULT.
  always_comb begin
    InReady_SO  = 1'b0;
    OutValid_SO = 1'b0;
    case (state_reg)
      IDLE, ACCUM: InReady_SO  = !Rst_RI;
      RESULT:      OutValid_SO = 1'b1;
      default: begin
        InReady_SO  = 1'b0;
        OutValid_SO = 1'b0;
      end
    endcase
  end

  // Datapath next values: fold each accepted beat in and capture the
  // result on the closing beat so it is visible in the following cycle.
  always_comb begin
    eq_acc_next    = eq_acc_reg;
    count_next     = count_reg;
    equal_next     = equal_reg;
    len_err_next   = len_err_reg;
    count_out_next = count_out_reg;
    if (accept) begin
      eq_acc_next = eq_inc;
      count_next  = count_inc;
      if (terminate) begin
        equal_next     = eq_inc && !len_err_now;
        len_err_next   = len_err_now;
        count_out_next = count_inc;
      end
    end
  end

  // Datapath registers; reset drops any partial word or pending result.
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      eq_acc_reg    <= 1'b0;
      count_reg     <= '0;
      equal_reg     <= 1'b0;
      len_err_reg   <= 1'b0;
      count_out_reg <= '0;
    end else begin
      eq_acc_reg    <= eq_acc_next;
      count_reg     <= count_next;
      equal_reg     <= equal_next;
      len_err_reg   <= len_err_next;
      count_out_reg <= count_out_next;
    end
  end

  assign Equal_DO  = equal_reg;
  assign LenErr_DO = len_err_reg;
  assign Count_DO  = count_out_reg;

endmodule

// File: tb/tb_serial_eq_comparator.sv
// tb_serial_eq_comparator
// Directed word scenarios followed by random traffic. Each cycle the
// outputs are compared with a word-level reference model that collects
// beats in queues and judges the whole word when it closes.
module tb_serial_eq_comparator;

  localparam int N  = 4;
  localparam int CW = $clog2(N) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    a;
  logic [1:0]    b;
  logic          last;
  logic          out_valid;
  logic          out_ready;
  logic          equal;
  logic          len_err;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  serial_eq_comparator #(.NUM_DIBITS(N)) dut (
    .Clk_CI      (clk),
    .Rst_RI      (rst),
    .InValid_SI  (in_valid),
    .InReady_SO  (in_ready),
    .A_DI        (a),
    .B_DI        (b),
    .Last_SI     (last),
    .OutValid_SO (out_valid),
    .OutReady_SI (out_ready),
    .Equal_DO    (equal),
    .LenErr_DO   (len_err),
    .Count_DO    (count)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: beats of the open word, plus the last result.
  logic [1:0] word_a[$];
  logic [1:0] word_b[$];
  bit         busy   = 0;
  bit         exp_eq = 0;
  bit         exp_le = 0;
  int         exp_cnt = 0;
  bit         accepted;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Judge a complete word: equal only if every dibit pair matches and the
  // word closed with Last_SI exactly on beat N.
  task automatic close_word(input bit last_flag);
    bit same;
    same = 1;
    foreach (word_a[i]) if (word_a[i] != word_b[i]) same = 0;
    exp_cnt = word_a.size();
    exp_le  = !(last_flag && exp_cnt == N);
    exp_eq  = same && !exp_le;
    busy    = 1;
    word_a.delete();
    word_b.delete();
  endtask

  // One clock cycle: drive at the falling edge, check, then advance the
  // model by what the coming rising edge will do.
  task automatic cycle(input bit r, input bit v, input logic [1:0] da,
                       input logic [1:0] db, input bit l, input bit o);
    @(negedge clk);
    rst = r; in_valid = v; a = da; b = db; last = l; out_ready = o;
    #1;
    chk("in_ready", in_ready, !r && !busy);
    chk("out_valid", out_valid, busy);
    chk("equal", equal, exp_eq);
    chk("len_err", len_err, exp_le);
    chk("count", count, exp_cnt);
    accepted = 0;
    if (r) begin
      busy = 0; exp_eq = 0; exp_le = 0; exp_cnt = 0;
      word_a.delete();
      word_b.delete();
    end else if (busy) begin
      if (o) busy = 0;
    end else if (v) begin
      accepted = 1;
      word_a.push_back(da);
      word_b.push_back(db);
      if (l || word_a.size() == N) close_word(l);
    end
    $display("cyc rst=%0b v=%0b a=%0d b=%0d last=%0b ordy=%0b rdy=%0b ov=%0b eq=%0b le=%0b cnt=%0d",
             r, v, da, db, l, o, in_ready, out_valid, equal, len_err, count);
  endtask

  task automatic send_beat(input logic [1:0] da, input logic [1:0] db, input bit l);
    int tries;
    tries = 0;
    do begin
      cycle(0, 1, da, db, l, 1);
      tries++;
    end while (!accepted && tries < 20);
    if (!accepted) chk("accept_timeout", 0, 1);
  endtask

  // Send nbeats dibits of a8/b8 MSB first; Last_SI on beat last_at (0 = none).
  task automatic send_word(input logic [7:0] a8, input logic [7:0] b8,
                           input int nbeats, input int last_at);
    for (int i = 0; i < nbeats; i++) begin
      send_beat(a8[7-2*i -: 2], b8[7-2*i -: 2], (i + 1) == last_at);
    end
  endtask

  task automatic idle_cycle(input bit o);
    cycle(0, 0, 2'b00, 2'b00, 0, o);
  endtask

  logic [7:0] wa;
  logic [7:0] wb;
  int         bi;
  bit         rr, rv, rl, ro;
  logic [1:0] ra, rb;
  bit         stall_pat[7];

  initial begin
    rst = 1; in_valid = 0; a = 0; b = 0; last = 0; out_ready = 1;
    repeat (2) @(posedge clk);

    // Reset state
    cycle(1, 1, 2'b01, 2'b01, 0, 1);
    chk("rst_in_ready", in_ready, 0);
    idle_cycle(1);
    chk("rst_count", count, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);

    // Equal word, result the cycle after the last beat
    wa = 8'b10_01_11_00;
    send_word(wa, wa, 4, 4);
    idle_cycle(1);
    chk("eq_valid", out_valid, 1);
    chk("eq_equal", equal, 1);
    chk("eq_lenerr", len_err, 0);
    chk("eq_count", count, 4);

    // Mismatch on beat 2
    wb = 8'b10_00_11_00;
    send_word(wa, wb, 4, 4);
    idle_cycle(1);
    chk("mis_equal", equal, 0);
    chk("mis_lenerr", len_err, 0);
    chk("mis_count", count, 4);

    // Short word closed by Last_SI on beat 2
    send_word(wa, wa, 2, 2);
    idle_cycle(1);
    chk("short_equal", equal, 0);
    chk("short_lenerr", len_err, 1);
    chk("short_count", count, 2);

    // No Last_SI by beat 4, then the next beat starts a new word
    send_word(wa, wa, 4, 0);
    idle_cycle(1);
    chk("nolast_lenerr", len_err, 1);
    chk("nolast_count", count, 4);
    send_word(8'b11_00_00_00, 8'b11_00_00_00, 1, 1);
    idle_cycle(1);
    chk("newword_count", count, 1);
    chk("newword_lenerr", len_err, 1);

    // Backpressure: result held five cycles while beats are offered
    send_word(wa, wa, 4, 4);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, 2'b11, 2'b11, 1, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_ready", in_ready, 0);
      chk("bp_count", count, 4);
    end
    idle_cycle(1);
    idle_cycle(1);
    chk("bp_rel_valid", out_valid, 0);
    chk("bp_rel_ready", in_ready, 1);

    // Reset after two beats discards the partial word
    send_word(wb, wa, 2, 0);
    cycle(1, 0, 2'b00, 2'b00, 0, 1);
    idle_cycle(1);
    chk("rmid_valid", out_valid, 0);
    chk("rmid_count", count, 0);
    send_word(wa, wa, 4, 4);
    idle_cycle(1);
    chk("rmid_res_valid", out_valid, 1);
    chk("rmid_res_equal", equal, 1);
    chk("rmid_res_count", count, 4);
    idle_cycle(1);
    chk("rmid_single", out_valid, 0);

    // Stalled equal word: InValid 1,0,0,1,1,0,1
    stall_pat = '{1, 0, 0, 1, 1, 0, 1};
    bi = 0;
    foreach (stall_pat[i]) begin
      if (stall_pat[i]) begin
        cycle(0, 1, wa[7-2*bi -: 2], wa[7-2*bi -: 2], bi == 3, 1);
        bi++;
      end else begin
        idle_cycle(1);
      end
    end
    idle_cycle(1);
    chk("stall_valid", out_valid, 1);
    chk("stall_equal", equal, 1);
    chk("stall_lenerr", len_err, 0);
    chk("stall_count", count, 4);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      rr = ($urandom_range(0, 99) < 2);
      rv = ($urandom_range(0, 3) != 0);
      ra = 2'($urandom);
      rb = ($urandom_range(0, 3) != 0) ? ra : 2'($urandom);
      rl = ($urandom_range(0, 3) == 0);
      ro = ($urandom_range(0, 2) != 0);
      cycle(rr, rv, ra, rb, rl, ro);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_eq_comparator.md
SERIAL_EQ_COMPARATOR -- requirements
Module: serial_eq_comparator

Interface
REQ-001 The block SHALL have parameter NUM_DIBITS, default 4, giving the number of 2-bit beats per word; legal range 1..64.
REQ-002 Clk_CI  input  1  The single clock; all state SHALL update on the rising edge.
REQ-003 Rst_RI  input  1  Reset, synchronous and active-high.
REQ-004 InValid_SI  input  1  The upstream beat is valid.
REQ-005 InReady_SO  output  1  The block accepts a beat this cycle.
REQ-006 A_DI  input  2  Operand A dibit, MSB-first within the word.
REQ-007 B_DI  input  2  Operand B dibit, aligned with A_DI.
REQ-008 Last_SI  input  1  Marks the final beat of the word.
REQ-009 OutValid_SO  output  1  The result is valid.
REQ-010 OutReady_SI  input  1  Downstream accepts the result.
REQ-011 Equal_DO  output  1  1 when the whole word A equals word B and the length is correct.
REQ-012 LenErr_DO  output  1  The word length was not equal to NUM_DIBITS.
REQ-013 Count_DO  output  $clog2(NUM_DIBITS)+1  Number of beats accepted in the word.

Function
REQ-014 A beat SHALL be accepted only in a cycle where InValid_SI=1 and InReady_SO=1.
REQ-015 Per-beat equality SHALL be computed by one comparator_2 instance on A_DI/B_DI.
REQ-016 The block SHALL implement a three-state FSM with states IDLE, ACCUM and RESULT.
REQ-017 In IDLE and ACCUM, InReady_SO SHALL be 1; in RESULT, InReady_SO SHALL be 0.
REQ-018 IDLE: on acceptance, the block SHALL clear the accumulator, load eq_acc with that beat's equality and set count to 1.
- Then go to RESULT if the word is terminated (REQ-020), else go to ACCUM.
REQ-019 ACCUM: on acceptance, the block SHALL set eq_acc &= beat equality and increment count.
- Then go to RESULT if the word is terminated.
REQ-020 A word SHALL terminate on the accepted beat that has Last_SI=1, or on the NUM_DIBITS-th accepted beat, whichever comes first.
REQ-021 LenErr SHALL be set to 1 in either of these cases:
- the word terminates on Last_SI with count != NUM_DIBITS;
- the NUM_DIBITS-th beat is accepted with Last_SI=0.
REQ-022 A beat accepted after a NUM_DIBITS-terminated word with Last_SI=0 SHALL begin a new word.
REQ-023 Equal_DO SHALL equal eq_acc AND NOT LenErr_DO.
REQ-024 Latency: OutValid_SO SHALL rise in the cycle after the terminating beat is accepted.
REQ-025 RESULT: OutValid_SO SHALL be 1, and Equal_DO, LenErr_DO and Count_DO SHALL hold stable until OutReady_SI=1.
REQ-026 On the result handshake (OutValid_SO=1, OutReady_SI=1), the FSM SHALL go to IDLE in the next cycle and OutValid_SO SHALL drop.
REQ-027 Minimum word period SHALL be NUM_DIBITS+1 cycles with OutReady_SI held at 1.
REQ-028 Outside RESULT, OutValid_SO SHALL be 0, and Equal_DO, LenErr_DO and Count_DO SHALL retain their last result values.
REQ-029 InValid_SI=0 in ACCUM SHALL hold all state; there SHALL be no timeout.
REQ-030 Count_DO SHALL never exceed NUM_DIBITS; the counter SHALL be wide enough that no wrap-around occurs.

Reset
REQ-031 When Rst_RI=1 at a rising edge, the FSM SHALL go to IDLE and clear OutValid_SO, Equal_DO, LenErr_DO, Count_DO, eq_acc and count to 0.
REQ-032 While Rst_RI=1, InReady_SO SHALL be 0.
REQ-033 Reset SHALL take priority over any simultaneous beat or result handshake.
REQ-034 A reset in ACCUM or RESULT SHALL discard the partial word or the pending result, with no output produced.

Verification
REQ-035 Equal word (NUM_DIBITS=4, OutReady_SI=1):
- Stimulus: A=B={2'b10,2'b01,2'b11,2'b00} on back-to-back beats, Last_SI on beat 4.
- Response: the next cycle shows OutValid_SO=1, Equal_DO=1, LenErr_DO=0, Count_DO=4.
REQ-036 Mismatch:
- Stimulus: same as REQ-035 but B beat 2 = 2'b00.
- Response: Equal_DO=0, LenErr_DO=0, Count_DO=4.
REQ-037 Short word:
- Stimulus: A=B, Last_SI on beat 2.
- Response: Equal_DO=0, LenErr_DO=1, Count_DO=2.
- Stimulus: no Last_SI by beat 4.
- Response: LenErr_DO=1, Count_DO=4; the next beat starts a new word.
REQ-038 Backpressure:
- Stimulus: OutReady_SI=0 for 5 cycles in RESULT while InValid_SI=1.
- Response: outputs stable, InReady_SO=0, no beat consumed; release gives IDLE one cycle later.
REQ-039 Reset mid-word:
- Stimulus: Rst_RI pulsed after beat 2, then a full equal word.
- Response: a single result with Count_DO=4 and Equal_DO=1.
REQ-040 Stalls:
- Stimulus: InValid_SI toggled 1,0,0,1,1,0,1 across a 4-beat equal word.
- Response: the result is identical to REQ-035.
